// File: rtl/wisc_mem_pkg.sv
// wisc_mem_pkg
// Shared types and default widths for the WISC-15 unified memory arbiter.
//   state_e : arbiter transaction sequencer states
//   owner_e : which requester owns the transaction in flight
//   WISC_ADDR_W / WISC_DATA_W : default address and data widths
package wisc_mem_pkg;

   localparam int WISC_ADDR_W = 16;
   localparam int WISC_DATA_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP,
      HALTED
   } state_e;

   typedef enum logic {
      OWN_IF,
      OWN_D
   } owner_e;

endpackage

// File: rtl/wisc_mem_lat_timer.sv
// wisc_mem_lat_timer
// Down-counter that times the fixed memory read latency.
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   load      : load the counter with load_val (takes priority over dec)
//   dec       : decrement by one, saturating at zero
//   load_val  : value loaded on load
//   done      : counter is zero
module wisc_mem_lat_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             dec,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: a load restarts the interval, otherwise count down and park at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done = (cnt_q == '0);

endmodule

// File: rtl/wisc_mem_arbiter.sv
// wisc_mem_arbiter
// Shares one single-port fixed-latency memory between instruction fetch and
// the data (lw/sw) stage. Each transaction walks IDLE -> ISSUE -> WAIT -> RESP;
// a decoded hlt drains outstanding work and parks the arbiter in HALTED.
// Build option: define WISC_MEM_ARB_FAIR_EN to bound how many consecutive data
// grants can starve a waiting fetch (STREAK_MAX); otherwise data always wins.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   if_req/if_addr/if_ack/if_rdata: fetch requester handshake
//   d_req/d_we/d_addr/d_wdata     : data requester request
//   d_ack/d_rdata                 : data requester response
//   if_stall, d_stall             : pipeline stall qualifiers (combinational)
//   halt, halted                  : halt-drain handshake
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : memory port
module wisc_mem_arbiter
   import wisc_mem_pkg::*;
#(
   parameter int ADDR_W     = WISC_ADDR_W,
   parameter int DATA_W     = WISC_DATA_W,
   parameter int MEM_LAT    = 4,
   parameter int STREAK_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              if_stall,
   output logic              d_stall,
   input  logic              halt,
   output logic              halted,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int               CNT_W    = 4;
   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

   if (MEM_LAT < 1 || MEM_LAT > 15 || STREAK_MAX < 1) begin : g_param_check
      $error("wisc_mem_arbiter: MEM_LAT must be 1..15 and STREAK_MAX at least 1");
   end

   state_e            state_q, state_d;
   owner_e            owner_q, owner_d;
   logic              we_q, we_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              if_ack_q, if_ack_d;
   logic              d_ack_q, d_ack_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              halted_q, halted_d;
   logic              timer_load, timer_dec, timer_done;
   logic              grant_if, grant_d, fetch_first;

`ifdef WISC_MEM_ARB_FAIR_EN
   localparam int STREAK_W = $clog2(STREAK_MAX + 1);
   logic [STREAK_W-1:0] streak_q, streak_d;

   // Fetch jumps the queue once data has won STREAK_MAX times in a row over it.
   assign fetch_first = (streak_q == STREAK_W'(STREAK_MAX)) && d_req && if_req && !halt;
`else
   assign fetch_first = 1'b0;
`endif

   wisc_mem_lat_timer #(
      .CNT_W(CNT_W)
   ) u_lat_timer (
      .clk     (clk),
      .rst     (rst),
      .load    (timer_load),
      .dec     (timer_dec),
      .load_val(LAT_LOAD),
      .done    (timer_done)
   );

   // Sequencer next-state and registered-output logic. Memory-port and ack
   // outputs are computed for the state being entered so they line up with it.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      we_d        = we_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_ack_d    = 1'b0;
      d_ack_d     = 1'b0;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;
      halted_d    = 1'b0;
      timer_load  = 1'b0;
      timer_dec   = 1'b0;
      grant_if    = 1'b0;
      grant_d     = 1'b0;

      case (state_q)
         IDLE: begin
            // halt only blocks new fetches; a pending store/load still drains.
            if (fetch_first) begin
               grant_if = 1'b1;
            end else if (d_req) begin
               grant_d = 1'b1;
            end else if (if_req && !halt) begin
               grant_if = 1'b1;
            end else if (halt) begin
               state_d  = HALTED;
               halted_d = 1'b1;
            end

            if (grant_d) begin
               state_d     = ISSUE;
               owner_d     = OWN_D;
               we_d        = d_we;
               mem_en_d    = 1'b1;
               mem_we_d    = d_we;
               mem_addr_d  = d_addr;
               mem_wdata_d = d_wdata;
            end else if (grant_if) begin
               state_d    = ISSUE;
               owner_d    = OWN_IF;
               we_d       = 1'b0;
               mem_en_d   = 1'b1;
               mem_addr_d = if_addr;
            end
         end
         ISSUE: begin
            state_d    = WAIT;
            timer_load = 1'b1;
         end
         WAIT: begin
            timer_dec = 1'b1;
            if (timer_done) begin
               state_d = RESP;
               if (owner_q == OWN_IF) begin
                  if_ack_d   = 1'b1;
                  if_rdata_d = mem_rdata;
               end else begin
                  d_ack_d = 1'b1;
                  // Stores return nothing useful, so the last load value is kept.
                  if (!we_q) begin
                     d_rdata_d = mem_rdata;
                  end
               end
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         HALTED: begin
            state_d  = HALTED;
            halted_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

`ifdef WISC_MEM_ARB_FAIR_EN
      // Streak counts data wins over a waiting fetch; any fetch win or an idle
      // fetch requester resets it. It saturates at STREAK_MAX.
      streak_d = streak_q;
      if (!if_req || grant_if) begin
         streak_d = '0;
      end else if (grant_d && (streak_q != STREAK_W'(STREAK_MAX))) begin
         streak_d = streak_q + 1'b1;
      end
`endif
   end

   // All arbiter state and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         owner_q     <= OWN_IF;
         we_q        <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_ack_q    <= 1'b0;
         d_ack_q     <= 1'b0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         halted_q    <= 1'b0;
`ifdef WISC_MEM_ARB_FAIR_EN
         streak_q    <= '0;
`endif
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         we_q        <= we_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_ack_q    <= if_ack_d;
         d_ack_q     <= d_ack_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
         halted_q    <= halted_d;
`ifdef WISC_MEM_ARB_FAIR_EN
         streak_q    <= streak_d;
`endif
      end
   end

   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign if_ack    = if_ack_q;
   assign d_ack     = d_ack_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign halted    = halted_q;
   assign if_stall  = if_req & ~if_ack_q;
   assign d_stall   = d_req & ~d_ack_q;

endmodule

// File: tb/tb_wisc_mem_arbiter.sv
// tb_wisc_mem_arbiter
// Self-checking bench for wisc_mem_arbiter with MEM_LAT=4, STREAK_MAX=2.
// Honours WISC_MEM_ARB_FAIR_EN when computing expected grant order.
module tb_wisc_mem_arbiter;

   localparam int LAT         = 4;
   localparam int STREAK      = 2;
   localparam int RAND_CYCLES = 400;
`ifdef WISC_MEM_ARB_FAIR_EN
   localparam bit FAIR = 1'b1;
`else
   localparam bit FAIR = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        if_req, if_ack, d_req, d_we, d_ack;
   logic [15:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
   logic        if_stall, d_stall, halt, halted;
   logic        mem_en, mem_we;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;

   logic [15:0] mem    [256];
   logic [15:0] pipe   [LAT];
   logic [15:0] shadow [256];

   int vectors;
   int miscompares;

   typedef struct {
      logic        is_data;
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_rdata;
   } vec_t;

   vec_t vecs [8];

   // Reference-model state for the randomized phase.
   int          c, free_at, ack_at, grant_at, streak, n_grants;
   bit          m_pend, m_is_d, ack_if_now, ack_d_now, fetch_wins;
   logic        m_we;
   logic [15:0] m_addr, m_wdata, m_data, hold_if, hold_d;
   logic        got_if [6];

   wisc_mem_arbiter #(
      .ADDR_W    (16),
      .DATA_W    (16),
      .MEM_LAT   (LAT),
      .STREAK_MAX(STREAK)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_ack   (if_ack),
      .if_rdata (if_rdata),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_ack    (d_ack),
      .d_rdata  (d_rdata),
      .if_stall (if_stall),
      .d_stall  (d_stall),
      .halt     (halt),
      .halted   (halted),
      .mem_en   (mem_en),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Contents a freshly reset memory holds at each address.
   function automatic logic [15:0] memInit(input logic [7:0] a);
      if (a == 8'h10) return 16'hB123;
      return {a, ~a};
   endfunction

   // Fixed-latency memory: reinitialised on reset, read data emerges LAT
   // cycles after the mem_en cycle; 16'hDEAD fills the pipe otherwise so a
   // mistimed capture shows up.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) mem[i] <= memInit(8'(i));
      end else if (mem_en && mem_we) begin
         mem[mem_addr[7:0]] <= mem_wdata;
      end
      pipe[0] <= mem_en ? mem[mem_addr[7:0]] : 16'hDEAD;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign mem_rdata = pipe[LAT-1];

   task automatic checkOutput(input string name, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkOutputWord(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One isolated transaction: request in cycle 0, mem_en in 1, ack in LAT+2.
   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      if (v.is_data) begin
         d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
      end else begin
         if_req = 1'b1; if_addr = v.addr;
      end
      #1;
      checkOutput("tbl stall c0", v.is_data ? d_stall : if_stall, 1'b1);
      for (int k = 1; k <= LAT + 2; k++) begin
         @(negedge clk);
         checkOutput("tbl mem_en", mem_en, k == 1);
         if (k == 1) begin
            checkOutput("tbl mem_we", mem_we, v.is_data && v.we);
            checkOutputWord("tbl mem_addr", mem_addr, v.addr);
            if (v.is_data && v.we) checkOutputWord("tbl mem_wdata", mem_wdata, v.wdata);
         end
         checkOutput("tbl own ack", v.is_data ? d_ack : if_ack, k == LAT + 2);
         checkOutput("tbl other ack", v.is_data ? if_ack : d_ack, 1'b0);
         checkOutput("tbl stall", v.is_data ? d_stall : if_stall, k != LAT + 2);
         if (k == LAT + 2) begin
            checkOutputWord("tbl rdata", v.is_data ? d_rdata : if_rdata, v.exp_rdata);
            d_req = 1'b0; if_req = 1'b0;
         end
      end
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      rst = 1'b1; halt = 1'b0;
      if_req = 1'b0; if_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

      vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hB123};
      vecs[1] = '{1'b1, 1'b1, 16'h0040, 16'hBEEF, 16'h0000};
      vecs[2] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 16'hBEEF};
      vecs[3] = '{1'b0, 1'b0, 16'h0041, 16'h0000, memInit(8'h41)};
      vecs[4] = '{1'b1, 1'b1, 16'h00FF, 16'h1234, 16'hBEEF};
      vecs[5] = '{1'b1, 1'b0, 16'h00FF, 16'h0000, 16'h1234};
      vecs[6] = '{1'b0, 1'b0, 16'h00FF, 16'h0000, 16'h1234};
      vecs[7] = '{1'b1, 1'b0, 16'h0007, 16'h0000, memInit(8'h07)};

      // Reset state.
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst mem_en", mem_en, 1'b0);
      checkOutput("rst mem_we", mem_we, 1'b0);
      checkOutputWord("rst mem_addr", mem_addr, 16'h0000);
      checkOutputWord("rst mem_wdata", mem_wdata, 16'h0000);
      checkOutput("rst if_ack", if_ack, 1'b0);
      checkOutput("rst d_ack", d_ack, 1'b0);
      checkOutputWord("rst if_rdata", if_rdata, 16'h0000);
      checkOutputWord("rst d_rdata", d_rdata, 16'h0000);
      checkOutput("rst halted", halted, 1'b0);
      checkOutput("rst if_stall", if_stall, 1'b0);
      rst = 1'b0;

      // Isolated transactions from the table.
      for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

      // Simultaneous requests: data first, fetch follows one slot later.
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0050;
      if_req = 1'b1; if_addr = 16'h0060;
      for (int k = 1; k <= 13; k++) begin
         @(negedge clk);
         checkOutput("both mem_en", mem_en, k == 1 || k == 8);
         if (k == 1) checkOutputWord("both d addr", mem_addr, 16'h0050);
         if (k == 8) checkOutputWord("both if addr", mem_addr, 16'h0060);
         checkOutput("both d_ack", d_ack, k == 6);
         checkOutput("both if_ack", if_ack, k == 13);
         if (k == 6) begin
            checkOutputWord("both d_rdata", d_rdata, memInit(8'h50));
            d_req = 1'b0;
         end
         if (k == 13) begin
            checkOutputWord("both if_rdata", if_rdata, memInit(8'h60));
            if_req = 1'b0;
         end
      end

      // Both requesters held: six grants, order depends on fairness.
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0030;
      if_req = 1'b1; if_addr = 16'h0020;
      n_grants = 0;
      for (int k = 1; k <= 41; k++) begin
         @(negedge clk);
         if (mem_en) begin
            if (n_grants < 6) got_if[n_grants] = (mem_addr == 16'h0020);
            n_grants++;
         end
         if (k == 41) begin
            d_req = 1'b0; if_req = 1'b0;
         end
      end
      checkOutputWord("streak grant count", 16'(n_grants), 16'd6);
      for (int g = 0; g < 6; g++)
         checkOutput("streak grant order", got_if[g], FAIR && (g % 3 == 2));
      @(negedge clk);

      // Reset during a load drops it; the held request is re-issued.
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0022;
      @(negedge clk);
      checkOutput("rstmid mem_en c1", mem_en, 1'b1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("rstmid mem_en", mem_en, 1'b0);
      checkOutput("rstmid mem_we", mem_we, 1'b0);
      checkOutputWord("rstmid mem_addr", mem_addr, 16'h0000);
      checkOutput("rstmid d_ack", d_ack, 1'b0);
      checkOutputWord("rstmid d_rdata", d_rdata, 16'h0000);
      checkOutputWord("rstmid if_rdata", if_rdata, 16'h0000);
      checkOutput("rstmid halted", halted, 1'b0);
      rst = 1'b0;
      for (int k = 5; k <= 10; k++) begin
         @(negedge clk);
         checkOutput("rstmid reissue mem_en", mem_en, k == 5);
         checkOutput("rstmid d_ack", d_ack, k == 10);
         if (k == 10) begin
            checkOutputWord("rstmid d_rdata", d_rdata, memInit(8'h22));
            d_req = 1'b0;
         end
      end

      // Randomized traffic against the reference model.
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 256; i++) shadow[i] = memInit(8'(i));
      c = 0; free_at = 0; ack_at = -1; grant_at = -10; streak = 0;
      m_pend = 1'b0; m_is_d = 1'b0; m_we = 1'b0;
      m_addr = '0; m_wdata = '0; m_data = '0; hold_if = '0; hold_d = '0;
      repeat (RAND_CYCLES) begin
         ack_if_now = m_pend && !m_is_d && (c == ack_at);
         ack_d_now  = m_pend && m_is_d && (c == ack_at);
         if (ack_if_now) hold_if = m_data;
         if (ack_d_now && !m_we) hold_d = m_data;
         checkOutput("rnd if_ack", if_ack, ack_if_now);
         checkOutput("rnd d_ack", d_ack, ack_d_now);
         checkOutput("rnd mem_en", mem_en, m_pend && (c == grant_at + 1));
         if (m_pend && (c == grant_at + 1)) begin
            checkOutputWord("rnd mem_addr", mem_addr, m_addr);
            checkOutput("rnd mem_we", mem_we, m_we);
            if (m_we) checkOutputWord("rnd mem_wdata", mem_wdata, m_wdata);
         end
         checkOutputWord("rnd if_rdata", if_rdata, hold_if);
         checkOutputWord("rnd d_rdata", d_rdata, hold_d);
         if (ack_if_now || ack_d_now) m_pend = 1'b0;

         // Requesters hold until acked, then may re-request or go quiet.
         if (!d_req || ack_d_now) begin
            if ($urandom_range(0, 3) != 0) begin
               d_req = 1'b1;
               d_we = 1'($urandom_range(0, 1));
               d_addr = 16'($urandom_range(0, 31));
               d_wdata = 16'($urandom);
            end else begin
               d_req = 1'b0;
            end
         end
         if (!if_req || ack_if_now) begin
            if ($urandom_range(0, 3) != 0) begin
               if_req = 1'b1;
               if_addr = 16'($urandom_range(0, 31));
            end else begin
               if_req = 1'b0;
            end
         end

         // Grant decision for the inputs sampled at the end of this cycle.
         if (!if_req) streak = 0;
         if (c >= free_at && (d_req || if_req)) begin
            fetch_wins = (FAIR && streak == STREAK && d_req && if_req) || !d_req;
            if (fetch_wins) begin
               m_is_d = 1'b0; m_we = 1'b0; m_addr = if_addr;
               m_data = shadow[if_addr[7:0]];
               streak = 0;
            end else begin
               m_is_d = 1'b1; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
               if (d_we) shadow[d_addr[7:0]] = d_wdata;
               else m_data = shadow[d_addr[7:0]];
               if (if_req && streak < STREAK) streak++;
            end
            m_pend = 1'b1;
            grant_at = c;
            ack_at = c + LAT + 2;
            free_at = c + LAT + 3;
         end
         @(negedge clk);
         c++;
      end
      rst = 1'b1; d_req = 1'b0; if_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // Halt during a data WAIT: load completes, then the arbiter parks.
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0033;
      if_req = 1'b1; if_addr = 16'h0044;
      for (int k = 1; k <= 28; k++) begin
         @(negedge clk);
         checkOutput("halt mem_en", mem_en, k == 1);
         checkOutput("halt d_ack", d_ack, k == 6);
         checkOutput("halt if_ack", if_ack, 1'b0);
         checkOutput("halt halted", halted, k >= 8);
         if (k >= 8) checkOutput("halt if_stall", if_stall, 1'b1);
         if (k == 3) halt = 1'b1;
         if (k == 6) begin
            checkOutputWord("halt d_rdata", d_rdata, memInit(8'h33));
            d_req = 1'b0;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
